// File: rtl/adc_pkg.sv
// ----------------------------------------------------------------------------
// adc_pkg
// Shared definitions for the AD7685 scan scheduler:
//   scan_state_t    - scheduler FSM state encoding
//   SAMPLE_W        - ADC result width
//   DEF_SETTLE_CYC  - default mux settling time in CLK cycles
//   DEF_TIMEOUT_CYC - default CNV_START -> ADC_VALID limit in CLK cycles
// ----------------------------------------------------------------------------
package adc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ARM,
        ST_WAIT,
        ST_EMIT
    } scan_state_t;

    localparam int unsigned SAMPLE_W        = 16;
    localparam int unsigned DEF_SETTLE_CYC  = 20;
    localparam int unsigned DEF_TIMEOUT_CYC = 512;

endpackage

// File: rtl/adc_period_timer.sv
// ----------------------------------------------------------------------------
// adc_period_timer
// Reloadable 16-bit down-counter producing the periodic scan tick.
//   CLK    in  : clock
//   rst    in  : synchronous active-low reset (counter reloads)
//   ENABLE in  : run the counter
//   PERIOD in  : tick interval in CLK cycles, 0 stops ticking
//   tick   out : one-cycle strobe every PERIOD cycles while running
// ----------------------------------------------------------------------------
module adc_period_timer (
    input  logic        CLK,
    input  logic        rst,
    input  logic        ENABLE,
    input  logic [15:0] PERIOD,
    output logic        tick
);

    logic [15:0] cnt_q;
    logic [15:0] reload;
    logic        run;

    assign run    = ENABLE && (PERIOD != '0);
    assign reload = PERIOD - 16'd1;
    assign tick   = run && (cnt_q == '0);

    // PERIOD is only consulted on reload, so a new value applies from the
    // next period onwards; while stopped the counter tracks PERIOD-1.
    always_ff @(posedge CLK) begin
        if (!rst) begin
            cnt_q <= reload;
        end else if (!run) begin
            cnt_q <= reload;
        end else if (cnt_q == '0) begin
            cnt_q <= reload;
        end else begin
            cnt_q <= cnt_q - 16'd1;
        end
    end

endmodule

// File: rtl/adc_scan_scheduler.sv
// ----------------------------------------------------------------------------
// adc_scan_scheduler
// Scans the enabled channels of the analog mux in ascending order on a
// periodic tick or manual trigger, drives the ADC interface CNV_START strobe
// and emits each 16-bit result tagged with its channel.
//   CLK, rst                   : clock, synchronous active-low reset
//   ENABLE, PERIOD             : periodic scan control
//   CH_MASK                    : enabled channels, latched at scan start
//   TRIG                       : one-cycle manual scan request
//   CLR_ERR                    : clears OVERRUN / TIMEOUT_ERR
//   ADC_BUSY/VALID/RESULT      : status and data from the ADC interface
//   CNV_START                  : one-cycle conversion request
//   CH_SEL                     : mux select
//   SAMPLE/SAMPLE_CH/VALID     : captured result, its channel, strobe
//   SCAN_DONE, SCANNING        : scan completion strobe, scan-active level
//   OVERRUN, TIMEOUT_ERR       : sticky error flags
// ----------------------------------------------------------------------------
module adc_scan_scheduler
    import adc_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CH_W        = 2,
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                CLK,
    input  logic                rst,
    input  logic                ENABLE,
    input  logic [15:0]         PERIOD,
    input  logic [NUM_CH-1:0]   CH_MASK,
    input  logic                TRIG,
    input  logic                CLR_ERR,
    input  logic                ADC_BUSY,
    input  logic                ADC_VALID,
    input  logic [SAMPLE_W-1:0] ADC_RESULT,
    output logic                CNV_START,
    output logic [CH_W-1:0]     CH_SEL,
    output logic [SAMPLE_W-1:0] SAMPLE,
    output logic [CH_W-1:0]     SAMPLE_CH,
    output logic                SAMPLE_VALID,
    output logic                SCAN_DONE,
    output logic                SCANNING,
    output logic                OVERRUN,
    output logic                TIMEOUT_ERR
);

    localparam int unsigned SCNT_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE_CYC - 1);
    localparam logic [TCNT_W-1:0] TMO_LOAD    = TCNT_W'(TIMEOUT_CYC - 1);

    scan_state_t         state_q, state_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [SCNT_W-1:0]   settle_q, settle_d;
    logic [TCNT_W-1:0]   tmo_q, tmo_d;

    logic                cnv_q, svalid_q, done_q, scanning_q;
    logic                overrun_q, tmo_err_q;
    logic [SAMPLE_W-1:0] sample_q;
    logic [CH_W-1:0]     sample_ch_q;

    logic                cnv_d, svalid_d, done_d, scanning_d;
    logic                capture, set_ovr, set_tmo;

    logic                tick, req;
    logic [CH_W:0]       start_hit, next_hit;

    adc_period_timer u_timer (
        .CLK    (CLK),
        .rst    (rst),
        .ENABLE (ENABLE),
        .PERIOD (PERIOD),
        .tick   (tick)
    );

    assign req = tick || TRIG;

    // Lowest set bit of m above 'from' (or at it when incl=1).
    // Result MSB flags whether any channel was found.
    function automatic logic [CH_W:0] find_next(input logic [NUM_CH-1:0] m,
                                                input logic [CH_W-1:0]   from,
                                                input logic              incl);
        logic [CH_W:0] r;
        int unsigned   i;
        r = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            i = NUM_CH - 1 - k;
            if (m[i] && ((i > 32'(from)) || (incl && (i == 32'(from))))) begin
                r = {1'b1, i[CH_W-1:0]};
            end
        end
        return r;
    endfunction

    assign start_hit = find_next(CH_MASK, '0, 1'b1);
    assign next_hit  = find_next(mask_q, ptr_q, 1'b0);

    // State and output registers
    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            mask_q      <= '0;
            settle_q    <= '0;
            tmo_q       <= '0;
            cnv_q       <= 1'b0;
            svalid_q    <= 1'b0;
            done_q      <= 1'b0;
            scanning_q  <= 1'b0;
            overrun_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
            sample_q    <= '0;
            sample_ch_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            mask_q     <= mask_d;
            settle_q   <= settle_d;
            tmo_q      <= tmo_d;
            cnv_q      <= cnv_d;
            svalid_q   <= svalid_d;
            done_q     <= done_d;
            scanning_q <= scanning_d;
            if (capture) begin
                sample_q    <= ADC_RESULT;
                sample_ch_q <= ptr_q;
            end
            if (set_ovr) begin
                overrun_q <= 1'b1;
            end else if (CLR_ERR) begin
                overrun_q <= 1'b0;
            end
            if (set_tmo) begin
                tmo_err_q <= 1'b1;
            end else if (CLR_ERR) begin
                tmo_err_q <= 1'b0;
            end
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        mask_d   = mask_q;
        settle_d = settle_q;
        tmo_d    = tmo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req && start_hit[CH_W]) begin
                    state_d  = ST_SETTLE;
                    mask_d   = CH_MASK;
                    ptr_d    = start_hit[CH_W-1:0];
                    settle_d = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_ARM;
                end else begin
                    settle_d = settle_q - SCNT_W'(1);
                end
            end
            ST_ARM: begin
                if (!ADC_BUSY) begin
                    state_d = ST_WAIT;
                    tmo_d   = TMO_LOAD;
                end
            end
            ST_WAIT: begin
                // A result arriving on the last allowed cycle still counts.
                if (ADC_VALID) begin
                    state_d = ST_EMIT;
                end else if (tmo_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q - TCNT_W'(1);
                end
            end
            ST_EMIT: begin
                if (next_hit[CH_W]) begin
                    state_d  = ST_SETTLE;
                    ptr_d    = next_hit[CH_W-1:0];
                    settle_d = SETTLE_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered-output next values
    always_comb begin
        cnv_d    = (state_q == ST_ARM) && !ADC_BUSY;
        capture  = (state_q == ST_WAIT) && ADC_VALID;
        set_tmo  = (state_q == ST_WAIT) && !ADC_VALID && (tmo_q == '0);
        svalid_d = (state_q == ST_EMIT);
        done_d   = (state_q == ST_EMIT) && !next_hit[CH_W];
        set_ovr  = req && (state_q != ST_IDLE);
        // Keeping EMIT in the term holds SCANNING through the SCAN_DONE cycle.
        scanning_d = (state_d != ST_IDLE) || (state_q == ST_EMIT);
    end

    assign CNV_START    = cnv_q;
    assign CH_SEL       = ptr_q;
    assign SAMPLE       = sample_q;
    assign SAMPLE_CH    = sample_ch_q;
    assign SAMPLE_VALID = svalid_q;
    assign SCAN_DONE    = done_q;
    assign SCANNING     = scanning_q;
    assign OVERRUN      = overrun_q;
    assign TIMEOUT_ERR  = tmo_err_q;

endmodule

// File: doc/adc_scan_scheduler.md
# adc_scan_scheduler

Multi-channel sample scheduler for the AD7685 ADC front end. It sits between the system control logic and the existing ADC interface block and owns that block's `CNV_START` strobe. On a periodic timer tick or a manual trigger, it scans every enabled channel of the external analog mux in ascending order. For each channel it drives the mux select, waits for settling, starts a conversion, captures the 16-bit result and emits it tagged with its channel number.

## Interface
Parameters:
- `NUM_CH`, 4: number of mux channels.
- `CH_W`, 2: channel index width; equals clog2(`NUM_CH`).
- `SETTLE_CYC`, 20: CLK cycles between a `CH_SEL` change and `CNV_START`.
- `TIMEOUT_CYC`, 512: maximum CLK cycles from `CNV_START` to `ADC_VALID` before the scan aborts.

Ports:
- `CLK` in 1: sole clock.
- `rst` in 1: synchronous, active-low reset (`rst`=0 resets on the rising CLK edge).
- `ENABLE` in 1: allows periodic scans.
- `PERIOD` in 16: CLK cycles between periodic ticks; 0 disables periodic ticks.
- `CH_MASK` in `NUM_CH`: enabled channels, sampled at scan start.
- `TRIG` in 1: single-cycle manual scan request. Works regardless of `ENABLE`.
- `CLR_ERR` in 1: clears the sticky flags.
- `ADC_BUSY` in 1: BUSY from the ADC interface.
- `ADC_VALID` in 1: VALID from the ADC interface.
- `ADC_RESULT` in 16: RESULT from the ADC interface.
- `CNV_START` out 1: conversion request to the ADC interface, one cycle wide.
- `CH_SEL` out `CH_W`: analog mux select.
- `SAMPLE` out 16: captured result.
- `SAMPLE_CH` out `CH_W`: channel of `SAMPLE`.
- `SAMPLE_VALID` out 1: one-cycle strobe for `SAMPLE` and `SAMPLE_CH`.
- `SCAN_DONE` out 1: one-cycle strobe after the last channel of a scan.
- `SCANNING` out 1: high from scan start until return to IDLE.
- `OVERRUN` out 1: sticky; a trigger arrived while scanning.
- `TIMEOUT_ERR` out 1: sticky; `ADC_VALID` did not arrive within `TIMEOUT_CYC`.

## Operation
- **Period timer.** A 16-bit down-counter runs when `ENABLE`=1 and `PERIOD`≠0. It loads `PERIOD`-1 and emits `tick` when it reaches 0, then reloads. Writing a new `PERIOD` value takes effect at the next reload. When `ENABLE`=0 the counter is held at `PERIOD`-1.
- **Scan request.** The request is `tick` OR `TRIG`.
  - In IDLE with the mask nonzero: latch `CH_MASK` into `mask_q`, set the pointer to the lowest set bit and go to SETTLE.
  - In IDLE with the mask zero: ignore the request. No strobes, no flags.
  - When not in IDLE: set `OVERRUN`=1 and drop the request.
- **FSM states:**
  - IDLE.
  - SETTLE: drive `CH_SEL` to the pointer and count `SETTLE_CYC` cycles. Then go to ARM.
  - ARM: wait for `ADC_BUSY`=0. Then pulse `CNV_START` for one cycle, load the timeout counter and go to WAIT.
  - WAIT: on `ADC_VALID`=1, capture `ADC_RESULT` into `SAMPLE` and go to EMIT. If the timeout counter reaches 0, set `TIMEOUT_ERR` and go to IDLE without `SCAN_DONE`.
  - EMIT: `SAMPLE_VALID`=1 for one cycle.
    - If a higher enabled channel exists in `mask_q`, move the pointer to it and go to SETTLE.
    - Otherwise pulse `SCAN_DONE` and go to IDLE.
- **Sticky flags.** `CLR_ERR`=1 clears both sticky flags. If `CLR_ERR` and a set-event occur in the same cycle, the set wins.
- **Channel selection.** Channel search is a priority encoder over `mask_q` bits strictly above the current pointer. Channels are never revisited within a scan.

## Timing
- **Reset values.** `CNV_START`, `SAMPLE_VALID`, `SCAN_DONE`, `SCANNING`, `OVERRUN` and `TIMEOUT_ERR` are 0. `SAMPLE`=0, `SAMPLE_CH`=0, `CH_SEL`=0. FSM is in IDLE and the timer is reloaded.
- **Reset mid-scan.** Abort immediately to the reset state. `CNV_START` is never held high across reset.
- **Scan start.** The request is seen on cycle N. `SCANNING`=1 and `CH_SEL` is valid from N+1.
- **First conversion start.** `CNV_START` asserts no earlier than N+1+`SETTLE_CYC`. It is delayed further while `ADC_BUSY`=1.
- **Result output.** `SAMPLE_VALID` asserts exactly 2 cycles after the cycle in which `ADC_VALID`=1. `SAMPLE` and `SAMPLE_CH` hold their values until the next capture.
- **Scan end.** `SCAN_DONE` coincides with the last `SAMPLE_VALID`. `SCANNING` drops on the following cycle.
- **Simultaneous requests.** `tick` and `TRIG` in the same IDLE cycle start one scan, with no `OVERRUN`.
- **Request on the IDLE-return edge.** A request arriving in the same cycle as the EMIT→IDLE transition counts as an `OVERRUN`.
- **Timeout counter width.** The counter is wide enough for `TIMEOUT_CYC`. A timeout also drops `SCANNING` on the next cycle.

## Structure
- **Shared package `adc_pkg`.** Holds the FSM state encoding (IDLE, SETTLE, ARM, WAIT, EMIT), the 16-bit sample width constant and the default `SETTLE_CYC`/`TIMEOUT_CYC`.
- **Sub-module `adc_period_timer`.** Contains the reloadable down-counter and tick generation.
- **Top-level logic.** The FSM and the next-channel priority encoder stay in the top level.

## Test plan
- **Periodic scan.** `PERIOD`=1000, `CH_MASK`=4'b1011, `ENABLE`=1, behavioural ADC model (VALID 100 cycles after start). Expect per tick: samples for channels 0, 1, 3 in that order, each `CNV_START` ≥20 cycles after its `CH_SEL` change, then `SCAN_DONE` with the channel-3 sample.
- **Manual trigger while disabled.** `ENABLE`=0, `TRIG` pulse, `CH_MASK`=4'b0100. Expect exactly one sample with `SAMPLE_CH`=2 and its value equal to the model result 16'hA5C3.
- **Overrun.** `TRIG` during WAIT. Expect `OVERRUN`=1, no extra scan, and `OVERRUN`=0 one cycle after `CLR_ERR`.
- **Timeout.** Model never asserts VALID, `TIMEOUT_CYC`=512. Expect `TIMEOUT_ERR`=1 at 512 cycles after `CNV_START`, return to IDLE, no `SCAN_DONE`.
- **BUSY hold-off.** `ADC_BUSY` held high 50 cycles past the end of SETTLE. Expect `CNV_START` exactly 1 cycle after `ADC_BUSY` falls.
- **Reset mid-scan.** `rst`=0 for 1 cycle during SETTLE of channel 1. Expect all outputs at reset values on the next cycle and no `CNV_START` until a new request arrives.
